// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph constants, pattern type, capture FSM states
// and the pattern-to-nibble decoder used by both the capture and encode paths.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } cap_state_t;

  // Bit order {g,f,e,d,c,b,a}, active-high
  localparam seg7_t SEG_BLANK = 7'h00;
  localparam seg7_t SEG_0 = 7'h3F;
  localparam seg7_t SEG_1 = 7'h06;
  localparam seg7_t SEG_2 = 7'h5B;
  localparam seg7_t SEG_3 = 7'h4F;
  localparam seg7_t SEG_4 = 7'h66;
  localparam seg7_t SEG_5 = 7'h6D;
  localparam seg7_t SEG_6 = 7'h7D;
  localparam seg7_t SEG_7 = 7'h07;
  localparam seg7_t SEG_8 = 7'h7F;
  localparam seg7_t SEG_9 = 7'h6F;
  localparam seg7_t SEG_A = 7'h77;
  localparam seg7_t SEG_B = 7'h7C;
  localparam seg7_t SEG_C = 7'h39;
  localparam seg7_t SEG_D = 7'h5E;
  localparam seg7_t SEG_E = 7'h79;
  localparam seg7_t SEG_F = 7'h71;

  // Returns {bad, nibble}; anything that is not a hex glyph decodes as bad zero
  function automatic logic [4:0] seg7_to_nibble(input seg7_t p);
    logic [4:0] r;
    case (p)
      SEG_0:   r = {1'b0, 4'h0};
      SEG_1:   r = {1'b0, 4'h1};
      SEG_2:   r = {1'b0, 4'h2};
      SEG_3:   r = {1'b0, 4'h3};
      SEG_4:   r = {1'b0, 4'h4};
      SEG_5:   r = {1'b0, 4'h5};
      SEG_6:   r = {1'b0, 4'h6};
      SEG_7:   r = {1'b0, 4'h7};
      SEG_8:   r = {1'b0, 4'h8};
      SEG_9:   r = {1'b0, 4'h9};
      SEG_A:   r = {1'b0, 4'hA};
      SEG_B:   r = {1'b0, 4'hB};
      SEG_C:   r = {1'b0, 4'hC};
      SEG_D:   r = {1'b0, 4'hD};
      SEG_E:   r = {1'b0, 4'hE};
      SEG_F:   r = {1'b0, 4'hF};
      default: r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_sync.sv
// Multi-bit flop-chain synchroniser; every bit travels through STAGES flops.
module seg7_sync #(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [STAGES];

  // Shift chain, cleared to zero by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(STAGES); i++) stage_r[i] <= {WIDTH{1'b0}};
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/seg7_capture.sv
// Samples an external 7-segment drive, waits for it to settle and emits the decoded
// nibble on a valid/ready register. Define SEG7_CAPTURE_DP_EN to capture the dp line too.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned DROP_W        = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [6:0]        seg,
`ifdef SEG7_CAPTURE_DP_EN
  input  logic              seg_dp,
  output logic              digit_dp,
`endif
  output logic [3:0]        digit,
  output logic              digit_bad,
  output logic              digit_valid,
  input  logic              digit_ready,
  output logic [DROP_W-1:0] drop_count
);

`ifdef SEG7_CAPTURE_DP_EN
  localparam int unsigned PW = 8;
  logic [PW-1:0] pat_in_s;
  assign pat_in_s = {seg_dp, seg};
`else
  localparam int unsigned PW = 7;
  logic [PW-1:0] pat_in_s;
  assign pat_in_s = seg;
`endif

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [PW-1:0]    pat_sync_s;
  logic [PW-1:0]    cand_r;
  logic [PW-1:0]    last_r;
  logic [CNT_W-1:0] cnt_r;
  cap_state_t       state_r;

  logic             match_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             accept_s;
  logic [PW-1:0]    accept_pat_s;
  logic             emit_s;
  logic [4:0]       dec_s;

  seg7_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (pat_in_s),
    .q     (pat_sync_s)
  );

  // Acceptance decision; in IDLE the live pattern is the candidate itself
  always_comb begin
    match_s      = (pat_sync_s == cand_r);
    cnt_inc_s    = cnt_r + CNT_W'(1);
    accept_s     = 1'b0;
    accept_pat_s = cand_r;
    case (state_r)
      ST_IDLE: begin
        accept_pat_s = pat_sync_s;
        if ((pat_sync_s != last_r) && (STABLE_CYCLES == 32'd1)) accept_s = 1'b1;
        else                                                     accept_s = 1'b0;
      end
      ST_SETTLE: begin
        if (match_s && (cnt_inc_s == CNT_W'(STABLE_CYCLES))) accept_s = 1'b1;
        else                                                  accept_s = 1'b0;
      end
      default: accept_s = 1'b0;
    endcase
    emit_s = accept_s && (accept_pat_s != {PW{1'b0}});
    dec_s  = seg7_to_nibble(accept_pat_s[6:0]);
  end

  // Stability FSM plus the output register and drop counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cand_r      <= {PW{1'b0}};
      last_r      <= {PW{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      digit       <= 4'h0;
      digit_bad   <= 1'b0;
      digit_valid <= 1'b0;
      drop_count  <= {DROP_W{1'b0}};
`ifdef SEG7_CAPTURE_DP_EN
      digit_dp    <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pat_sync_s != last_r) begin
            if (accept_s) begin
              last_r <= pat_sync_s;
            end else begin
              cand_r  <= pat_sync_s;
              cnt_r   <= CNT_W'(1);
              state_r <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (match_s) begin
            if (accept_s) begin
              last_r  <= cand_r;
              state_r <= ST_IDLE;
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end else if (pat_sync_s == last_r) begin
            // Glitch fell back to what is already shown: nothing new to report
            state_r <= ST_IDLE;
          end else begin
            cand_r <= pat_sync_s;
            cnt_r  <= CNT_W'(1);
          end
        end
        default: state_r <= ST_IDLE;
      endcase

      if (emit_s) begin
        if (!digit_valid || digit_ready) begin
          digit       <= dec_s[3:0];
          digit_bad   <= dec_s[4];
          digit_valid <= 1'b1;
`ifdef SEG7_CAPTURE_DP_EN
          digit_dp    <= accept_pat_s[7];
`endif
        end else if (drop_count != {DROP_W{1'b1}}) begin
          drop_count <= drop_count + DROP_W'(1);
        end
      end else if (digit_valid && digit_ready) begin
        digit_valid <= 1'b0;
      end
    end
  end

endmodule
